// File: rtl/rle_decoder_if.sv
// Record-in / pixel-write-out bundle for the RLE decoder.
// The record source drives the i_* fields and the frame-buffer stall; the decoder drives the o_* fields.
interface rle_decoder_if #(
  parameter int ChannelLength = 640,
  parameter int ChannelHeight = 480,
  parameter int MaxRunLength  = 12
);
  localparam int XW = $clog2(ChannelLength);
  localparam int YW = $clog2(ChannelHeight);

  logic                    i_valid;
  logic [7:0]              i_val;
  logic [MaxRunLength-1:0] i_count;
  logic [XW-1:0]           i_start_x;
  logic [YW-1:0]           i_row;
  logic                    i_wr_stall;
  logic                    o_busy;
  logic                    o_wr_en;
  logic [XW-1:0]           o_wr_x;
  logic [YW-1:0]           o_wr_y;
  logic [7:0]              o_wr_val;
  logic                    o_done;
  logic                    o_err;

  modport master (
    output i_valid, i_val, i_count, i_start_x, i_row, i_wr_stall,
    input  o_busy, o_wr_en, o_wr_x, o_wr_y, o_wr_val, o_done, o_err
  );

  modport slave (
    input  i_valid, i_val, i_count, i_start_x, i_row, i_wr_stall,
    output o_busy, o_wr_en, o_wr_x, o_wr_y, o_wr_val, o_done, o_err
  );
endinterface

// File: rtl/rle_decoder.sv
// Expands (value, count, start x, row) run records into one pixel write per cycle.
// The write for cycle c is decided at the edge that starts cycle c, so i_wr_stall sampled
// at that edge suppresses that cycle's write. Records that run past the line end are clipped.
module rle_decoder #(
  parameter int ChannelLength = 640,
  parameter int ChannelHeight = 480,
  parameter int MaxRunLength  = 12
) (
  input logic          CLK,
  input logic          RST,
  rle_decoder_if.slave bus
);
  localparam int XW = $clog2(ChannelLength);
  localparam int YW = $clog2(ChannelHeight);
  localparam int CW = MaxRunLength;

  localparam logic [XW:0] XLimit = ChannelLength[XW:0];
  localparam logic [YW:0] YLimit = ChannelHeight[YW:0];
  localparam logic [CW:0] CLimit = ChannelLength[CW:0];

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;          // next x to write
  logic [CW-1:0]   rem_q, rem_d;      // pixels still to write
  logic [7:0]      val_q, val_d;
  logic [YW-1:0]   row_q, row_d;
  logic            wr_en_q, wr_en_d;
  logic [XW-1:0]   wr_x_q, wr_x_d;
  logic [YW-1:0]   wr_y_q, wr_y_d;
  logic [7:0]      wr_val_q, wr_val_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // Acceptance checks on the offered record; the sum is one bit wider than the count field.
  logic          rec_illegal;
  logic          rec_clip;
  logic [CW:0]   start_ext;
  logic [CW:0]   end_ext;
  logic [CW-1:0] count_eff;
  logic          issue;
  logic [XW-1:0] run_x;
  logic [CW-1:0] run_rem;

  assign start_ext   = {{(CW + 1 - XW){1'b0}}, bus.i_start_x};
  assign end_ext     = {1'b0, bus.i_count} + start_ext;
  assign rec_illegal = (bus.i_count == '0) || ({1'b0, bus.i_start_x} >= XLimit)
                    || ({1'b0, bus.i_row} >= YLimit);
  assign rec_clip    = (end_ext > CLimit);
  assign count_eff   = rec_clip ? CW'(CLimit - start_ext) : bus.i_count;

  // Next-state and next-output logic for the IDLE/EXPAND/DONE sequencer.
  // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    rem_d    = rem_q;
    val_d    = val_q;
    row_d    = row_q;
    wr_en_d  = 1'b0;
    wr_x_d   = wr_x_q;
    wr_y_d   = wr_y_q;
    wr_val_d = wr_val_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    issue    = 1'b0;
    run_x    = x_q;
    run_rem  = rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          if (rec_illegal) begin
            err_d = 1'b1;
          end else begin
            err_d   = rec_clip;
            state_d = S_EXPAND;
            val_d   = bus.i_val;
            row_d   = bus.i_row;
            run_x   = bus.i_start_x;
            run_rem = count_eff;
            issue   = 1'b1;
          end
        end
      end
      S_EXPAND: begin
        if (rem_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          issue = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A stalled cycle parks the run position; write address/data hold their last values.
    if (issue) begin
      x_d   = run_x;
      rem_d = run_rem;
      if (!bus.i_wr_stall) begin
        wr_en_d  = 1'b1;
        wr_x_d   = run_x;
        wr_y_d   = row_d;
        wr_val_d = val_d;
        x_d      = run_x + 1'b1;
        rem_d    = run_rem - 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset; reset mid-run simply abandons it.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      rem_q    <= '0;
      val_q    <= '0;
      row_q    <= '0;
      wr_en_q  <= 1'b0;
      wr_x_q   <= '0;
      wr_y_q   <= '0;
      wr_val_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      rem_q    <= rem_d;
      val_q    <= val_d;
      row_q    <= row_d;
      wr_en_q  <= wr_en_d;
      wr_x_q   <= wr_x_d;
      wr_y_q   <= wr_y_d;
      wr_val_q <= wr_val_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_busy   = (state_q != S_IDLE);
  assign bus.o_wr_en  = wr_en_q;
  assign bus.o_wr_x   = wr_x_q;
  assign bus.o_wr_y   = wr_y_q;
  assign bus.o_wr_val = wr_val_q;
  assign bus.o_done   = done_q;
  assign bus.o_err    = err_q;
endmodule
